stupid_toy_sender: RTL and testbench

Transmit-side counterpart of stupid_toy_loader; drives its data/load_enable interface. Accepts bytes from an upstream valid/ready source into a small FIFO. Presents each byte on data one cycle before a single-cycle load_enable strobe, then inserts a programmable idle gap. Sits between any byte producer and one or more stupid_toy_loader instances sharing clk.

---
 rtl/stupid_toy_pkg.sv | 14 +
 rtl/stupid_toy_fifo.sv | 57 +++++
 rtl/stupid_toy_sender.sv | 128 ++++++++++++
 tb/tb_stupid_toy_sender.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/stupid_toy_pkg.sv
// Shared definitions for the stupid_toy sender/loader pair: the sender FSM state
// encoding and the default byte width both sides agree on.
package stupid_toy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/stupid_toy_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate occupancy counter.
module stupid_toy_fifo
  import stupid_toy_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             full_next_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic is_full(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = is_full(wr_ptr_q, rd_ptr_q);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, do_pop};
  assign full_next_o = is_full(wr_ptr_d, rd_ptr_d);
  assign head_o      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/stupid_toy_sender.sv
// Byte sender for stupid_toy_loader: buffers upstream bytes, presents each one on
// data a cycle ahead of a single-cycle load_enable strobe, then idles GAP cycles.
module stupid_toy_sender
  import stupid_toy_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] data,
  output logic             load_enable,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty, fifo_full_next;
  logic             fifo_push, fifo_pop;
  logic             can_pop;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             le_q, le_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;

  stupid_toy_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifo_push),
    .data_i     (in_data),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .full_next_o(fifo_full_next)
  );

  // in_ready is a flop mirroring !full, so a pop on the same edge never frees a slot early.
  assign fifo_push = in_valid && in_ready_q && !fifo_full;
  assign can_pop   = !fifo_empty && !hold;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    le_d     = 1'b0;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        le_d    = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (GAP > 0) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (can_pop) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          state_d  = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (can_pop) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          state_d  = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      le_q       <= 1'b0;
      gap_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      le_q       <= le_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      in_ready_q <= !fifo_full_next;
    end
  end

  assign in_ready    = in_ready_q;
  assign data        = data_q;
  assign load_enable = le_q;
  assign busy        = (state_q != ST_IDLE);
  assign sent_count  = cnt_q;

endmodule

// File: tb/tb_stupid_toy_sender.sv
// Scoreboard bench: dut_a runs GAP=1 with a 4-bit strobe counter, dut_b runs GAP=0.
module tb_stupid_toy_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid_a, in_ready_a, hold_a, load_enable_a, busy_a;
  logic [7:0] in_data_a, data_a;
  logic [3:0] sent_count_a;
  logic       in_valid_b, in_ready_b, hold_b, load_enable_b, busy_b;
  logic [7:0] in_data_b, data_b;
  logic [15:0] sent_count_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [3:0]  exp_cnt_a = '0;
  logic [15:0] exp_cnt_b = '0;
  logic rst_pend = 1'b1;
  logic le_prev_a = 1'b0, le_prev_b = 1'b0;
  logic chk_per_a = 1'b0, chk_per_b = 1'b0, per_prev_a = 1'b0, per_prev_b = 1'b0;
  int   last_a = -1, last_b = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stupid_toy_sender #(.WIDTH(8), .DEPTH(4), .GAP(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .hold(hold_a), .data(data_a),
    .load_enable(load_enable_a), .busy(busy_a), .sent_count(sent_count_a)
  );

  stupid_toy_sender #(.WIDTH(8), .DEPTH(4), .GAP(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .hold(hold_b), .data(data_b),
    .load_enable(load_enable_b), .busy(busy_b), .sent_count(sent_count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected bytes on every strobe and tracks the strobe counter.
  always @(negedge clk) begin
    if (rst_pend) begin
      exp_q_a.delete();
      exp_q_b.delete();
      exp_cnt_a = '0;
      exp_cnt_b = '0;
    end
    if (chk_per_a && !per_prev_a) last_a = -1;
    if (chk_per_b && !per_prev_b) last_b = -1;
    chk("sent_count_a", sent_count_a, exp_cnt_a);
    chk("sent_count_b", sent_count_b, exp_cnt_b);
    if (load_enable_a) begin
      chk("strobe_a_expected", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) chk("data_a", data_a, exp_q_a.pop_front());
      if (chk_per_a && last_a >= 0) chk("period_a", cyc - last_a, 3);
      chk("le_a_single_cycle", le_prev_a, 0);
      last_a = cyc;
      exp_cnt_a = exp_cnt_a + 4'd1;
    end
    if (load_enable_b) begin
      chk("strobe_b_expected", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) chk("data_b", data_b, exp_q_b.pop_front());
      if (chk_per_b && last_b >= 0) chk("period_b", cyc - last_b, 2);
      chk("le_b_single_cycle", le_prev_b, 0);
      last_b = cyc;
      exp_cnt_b = exp_cnt_b + 16'd1;
    end
    le_prev_a  = load_enable_a;
    le_prev_b  = load_enable_b;
    per_prev_a = chk_per_a;
    per_prev_b = chk_per_b;
    rst_pend   = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit to_b, input logic [7:0] b);
    int   n;
    logic ok;
    n = 0;
    if (to_b) begin in_valid_b = 1'b1; in_data_b = b; end
    else begin in_valid_a = 1'b1; in_data_a = b; end
    ok = to_b ? in_ready_b : in_ready_a;
    while (!ok && n < 100) begin
      step();
      n++;
      ok = to_b ? in_ready_b : in_ready_a;
    end
    chk("push_accepted", ok, 1);
    if (ok) begin
      step();
      if (to_b) exp_q_b.push_back(b);
      else exp_q_a.push_back(b);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input bit to_b);
    int n;
    n = 0;
    while (n < 300 && ((to_b ? busy_b : busy_a) ||
           (to_b ? exp_q_b.size() : exp_q_a.size()) != 0)) begin
      step();
      n++;
    end
    chk("idle_reached", n < 300, 1);
  endtask

  initial begin
    logic [7:0] b2b[6];
    b2b[0] = 8'h3A; b2b[1] = 8'hFF; b2b[2] = 8'h00;
    b2b[3] = 8'h55; b2b[4] = 8'h11; b2b[5] = 8'h22;
    reset = 1'b1;
    in_valid_a = 1'b1; in_data_a = 8'hA5; hold_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 8'h00; hold_b = 1'b0;

    // Reset held two cycles with in_valid high
    step();
    step();
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_data", data_a, 8'h00);
    chk("rst_load_enable", load_enable_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_sent_count", sent_count_a, 0);
    reset = 1'b0;
    in_valid_a = 1'b0;
    step();
    chk("in_ready_after_release", in_ready_a, 1);
    repeat (3) step();
    chk("no_push_during_reset", busy_a, 0);

    // Single byte latency
    push(1'b0, 8'h3A);
    chk("single_e0_busy", busy_a, 0);
    step();
    chk("single_e1_data", data_a, 8'h3A);
    chk("single_e1_le", load_enable_a, 0);
    step();
    chk("single_e2_le", load_enable_a, 1);
    chk("single_e2_cnt", sent_count_a, 0);
    step();
    chk("single_e3_le", load_enable_a, 0);
    chk("single_e3_cnt", sent_count_a, 1);
    chk("single_e3_busy_gap", busy_a, 1);
    step();
    chk("single_e4_busy", busy_a, 0);

    // Back-to-back with GAP=1
    chk_per_a = 1'b1;
    foreach (b2b[i]) push(1'b0, b2b[i]);
    chk("b2b_ready_low_when_full", in_ready_a, 0);
    wait_idle(1'b0);
    chk_per_a = 1'b0;
    chk("b2b_sent_count", sent_count_a, 7);

    // GAP=0 on the second instance
    chk_per_b = 1'b1;
    push(1'b1, 8'h01);
    push(1'b1, 8'h80);
    push(1'b1, 8'h7E);
    push(1'b1, 8'hC3);
    wait_idle(1'b1);
    chk_per_b = 1'b0;
    chk("gap0_sent_count", sent_count_b, 4);

    // hold during LOAD, then reset during SETUP
    push(1'b0, 8'h3A);
    push(1'b0, 8'hFF);
    step();
    hold_a = 1'b1;
    chk("hold_in_load_le", load_enable_a, 1);
    step();
    chk("hold_strobe_done", load_enable_a, 0);
    repeat (4) step();
    chk("hold_busy", busy_a, 0);
    chk("hold_data_kept", data_a, 8'h3A);
    hold_a = 1'b0;
    step();
    chk("release_setup_data", data_a, 8'hFF);
    chk("release_setup_busy", busy_a, 1);
    chk("release_setup_le", load_enable_a, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_le", load_enable_a, 0);
    chk("mid_rst_data", data_a, 8'h00);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 0);
    reset = 1'b0;
    repeat (4) step();
    chk("post_rst_fifo_empty", busy_a, 0);
    chk("post_rst_in_ready", in_ready_a, 1);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) push(1'b0, 8'(8'h40 + i));
    wait_idle(1'b0);
    chk("wrap_final_count", sent_count_a, 1);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
